// File: rtl/arb_pkg.sv
// Shared constants for the arbitrated multiplexer: arbitration policy
// encodings and the select-width helper used to size channel indices.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker. Scans the request vector starting at a base
// index (ptr in round-robin mode, 0 in fixed mode), wrapping at N_IN-1 -> 0,
// and returns the first requester as a one-hot grant plus its binary index.
module rr_pick import arb_pkg::*; #(
  parameter  int N_IN  = 2,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] idx
);

  // First set request at or after the base index, wrapping within N_IN.
  always_comb begin
    int base;
    int j;
    logic [SEL_W-1:0] j_idx;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    base  = mode ? int'(ptr) : 0;
    j     = 0;
    j_idx = '0;
    for (int off = 0; off < N_IN; off++) begin
      j = base + off;
      if (j >= N_IN) j = j - N_IN;
      j_idx = SEL_W'(j);
      if (!found && req[j_idx]) begin
        found        = 1'b1;
        grant[j_idx] = 1'b1;
        idx          = j_idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-input registered multiplexer with arbitration. One requester is granted
// per cycle and its payload is captured into a one-entry output register.
//
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both 1. in_ready is only raised when the output
// register can take a word this cycle (empty, or being drained), so a loaded
// word is never overwritten before the consumer has taken it. Sources keep
// valid/data steady until accepted; the consumer may stall with out_ready=0.
module arb_mux import arb_pkg::*; #(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 2,
  parameter  int MODE  = ARB_RR,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  localparam logic IS_RR = (MODE == ARB_RR);

  logic [SEL_W-1:0] ptr;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] win_idx;
  logic             load_en;
  logic             load;

  rr_pick #(.N_IN(N_IN)) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .mode  (IS_RR),
    .grant (grant),
    .idx   (win_idx)
  );

  // The register can accept when empty or when its word leaves this cycle;
  // nothing is accepted while reset is held.
  always_comb begin
    load_en  = !out_valid || out_ready;
    in_ready = grant & {N_IN{load_en && reset}};
    load     = |in_ready;
  end

  // Output register: load the winner, or empty out once the consumer drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[win_idx*WIDTH +: WIDTH];
      out_sel   <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the last accepted channel; it stays
  // at 0 in fixed-priority mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (IS_RR && load) begin
      if (int'(win_idx) == N_IN - 1) ptr <= '0;
      else                           ptr <= win_idx + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: three instances (2-ch RR, 3-ch RR, 3-ch fixed priority).
module tb_arb_mux;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 3-channel round-robin instance
  logic [2:0]  d3_iv = '0;
  logic [95:0] d3_data = '0;
  logic        d3_ordy = 1'b0;
  logic [2:0]  d3_ir;
  logic        d3_ov;
  logic [31:0] d3_od;
  logic [1:0]  d3_os;

  // 2-channel round-robin instance
  logic [1:0]  d2_iv = '0;
  logic [63:0] d2_data = '0;
  logic        d2_ordy = 1'b0;
  logic [1:0]  d2_ir;
  logic        d2_ov;
  logic [31:0] d2_od;
  logic [0:0]  d2_os;

  // 3-channel fixed-priority instance
  logic [2:0]  f3_iv = '0;
  logic [95:0] f3_data = '0;
  logic        f3_ordy = 1'b0;
  logic [2:0]  f3_ir;
  logic        f3_ov;
  logic [31:0] f3_od;
  logic [1:0]  f3_os;

  arb_mux #(.WIDTH(32), .N_IN(3), .MODE(ARB_RR)) dut3 (
    .clk(clk), .reset(reset), .in_valid(d3_iv), .in_data(d3_data),
    .in_ready(d3_ir), .out_valid(d3_ov), .out_data(d3_od), .out_sel(d3_os),
    .out_ready(d3_ordy));

  arb_mux #(.WIDTH(32), .N_IN(2), .MODE(ARB_RR)) dut2 (
    .clk(clk), .reset(reset), .in_valid(d2_iv), .in_data(d2_data),
    .in_ready(d2_ir), .out_valid(d2_ov), .out_data(d2_od), .out_sel(d2_os),
    .out_ready(d2_ordy));

  arb_mux #(.WIDTH(32), .N_IN(3), .MODE(ARB_FIXED)) dutf (
    .clk(clk), .reset(reset), .in_valid(f3_iv), .in_data(f3_data),
    .in_ready(f3_ir), .out_valid(f3_ov), .out_data(f3_od), .out_sel(f3_os),
    .out_ready(f3_ordy));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-channel payload; changes only after that channel is accepted.
  int cnt[3] = '{0, 0, 0};
  function automatic logic [31:0] payload(input int ch, input int c);
    return 32'hA500_0000 | (32'(ch) << 16) | 32'(c);
  endfunction

  task automatic drive_d3_data();
    for (int i = 0; i < 3; i++) d3_data[i*32 +: 32] = payload(i, cnt[i]);
  endtask

  // Source-stability monitor on the 3-channel instance.
  logic [2:0]  prev_pend = '0;
  logic [95:0] prev_data = '0;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++)
        if (prev_pend[i] && d3_iv[i] && d3_data[i*32 +: 32] !== prev_data[i*32 +: 32]) begin
          n_miss++;
          $display("FAIL src_stable ch%0d: got %h want %h", i, d3_data[i*32 +: 32], prev_data[i*32 +: 32]);
        end
      prev_pend <= d3_iv & ~d3_ir;
      prev_data <= d3_data;
    end else begin
      prev_pend <= '0;
    end
  end

  typedef struct {
    logic [2:0] iv;
    logic       ordy;
    logic [2:0] ir;   // expected in_ready before the edge
    logic       ov;   // expected out_valid after the edge
    logic [1:0] sel;  // expected out_sel after the edge
  } vec_t;

  vec_t tbl[21];
  logic [31:0] exp_data;

  initial begin
    // idle, then ch2 alone (ptr 0 -> 0), then ch0 (ptr -> 1)
    tbl[0]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
    tbl[1]  = '{3'b100, 1'b1, 3'b100, 1'b1, 2'd2};
    tbl[2]  = '{3'b001, 1'b1, 3'b001, 1'b1, 2'd0};
    // all requesting: 1,2,0,1,2
    tbl[3]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1};
    tbl[4]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2};
    tbl[5]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0};
    tbl[6]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1};
    tbl[7]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2};
    // backpressure 4 cycles, then load in the draining cycle
    tbl[8]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd2};
    tbl[9]  = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd2};
    tbl[10] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd2};
    tbl[11] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd2};
    tbl[12] = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0};
    // drain to empty; empty register accepts even with out_ready=0
    tbl[13] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
    tbl[14] = '{3'b101, 1'b0, 3'b100, 1'b1, 2'd2};
    tbl[15] = '{3'b101, 1'b0, 3'b000, 1'b1, 2'd2};
    tbl[16] = '{3'b101, 1'b1, 3'b001, 1'b1, 2'd0};
    tbl[17] = '{3'b011, 1'b1, 3'b010, 1'b1, 2'd1};
    // ptr 2 with ch2 idle wraps to ch0
    tbl[18] = '{3'b011, 1'b1, 3'b001, 1'b1, 2'd0};
    tbl[19] = '{3'b000, 1'b0, 3'b000, 1'b1, 2'd0};
    tbl[20] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};

    exp_data = '0;
    drive_d3_data();

    // ---- reset state ----
    #1;
    chk("rst_ov",  32'(d3_ov), 32'd0);
    chk("rst_od",  d3_od, 32'd0);
    chk("rst_os",  32'(d3_os), 32'd0);
    chk("rst_ir",  32'(d3_ir), 32'd0);
    chk("rst_d2_ov", 32'(d2_ov), 32'd0);
    chk("rst_f3_ov", 32'(f3_ov), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ---- table on 3-channel RR ----
    for (int v = 0; v < 21; v++) begin
      @(negedge clk);
      d3_iv   = tbl[v].iv;
      d3_ordy = tbl[v].ordy;
      drive_d3_data();
      #1;
      chk($sformatf("v%0d_ir", v), 32'(d3_ir), 32'(tbl[v].ir));
      for (int i = 0; i < 3; i++)
        if (tbl[v].ir[i]) begin
          exp_data = payload(i, cnt[i]);
          cnt[i]++;
        end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", v), 32'(d3_ov), 32'(tbl[v].ov));
      chk($sformatf("v%0d_os", v), 32'(d3_os), 32'(tbl[v].sel));
      chk($sformatf("v%0d_od", v), d3_od, exp_data);
    end

    // ---- asynchronous reset mid-stream ----
    @(negedge clk);
    d3_iv = 3'b001; d3_ordy = 1'b0; drive_d3_data();
    #1;
    chk("mrst_pre_ir", 32'(d3_ir), 32'b001);
    cnt[0]++;
    @(posedge clk);
    #1;
    chk("mrst_pre_ov", 32'(d3_ov), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_ov", 32'(d3_ov), 32'd0);
    chk("mrst_od", d3_od, 32'd0);
    chk("mrst_os", 32'(d3_os), 32'd0);
    chk("mrst_ir", 32'(d3_ir), 32'd0);
    @(negedge clk);
    d3_iv = 3'b000; d3_ordy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_ov", 32'(d3_ov), 32'd0);
      chk("post_rst_od", d3_od, 32'd0);
      chk("post_rst_ir", 32'(d3_ir), 32'd0);
    end
    // ptr must be back at 0: ch0 beats ch2
    @(negedge clk);
    d3_iv = 3'b101; drive_d3_data();
    #1;
    chk("post_rst_ptr_ir", 32'(d3_ir), 32'b001);
    @(posedge clk);
    #1;
    chk("post_rst_os", 32'(d3_os), 32'd0);
    chk("post_rst_od2", d3_od, payload(0, cnt[0]));
    @(negedge clk);
    d3_iv = 3'b000;

    // ---- 2-channel: single request on ch1 ----
    @(negedge clk);
    d2_iv = 2'b10; d2_ordy = 1'b1;
    d2_data[63:32] = 32'hDEADBEEF; d2_data[31:0] = 32'h0000_1234;
    #1;
    chk("d2_ir", 32'(d2_ir), 32'b10);
    @(posedge clk);
    #1;
    chk("d2_ov", 32'(d2_ov), 32'd1);
    chk("d2_od", d2_od, 32'hDEADBEEF);
    chk("d2_os", 32'(d2_os), 32'd1);
    @(negedge clk);
    d2_iv = 2'b00;
    @(posedge clk);
    #1;
    chk("d2_drain_ov", 32'(d2_ov), 32'd0);

    // ---- fixed priority: ch1 always beats ch2 ----
    f3_data = {32'hCC00_0002, 32'hBB00_0001, 32'hAA00_0000};
    f3_ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      f3_iv = 3'b110;
      #1;
      chk("f3_ir", 32'(f3_ir), 32'b010);
      @(posedge clk);
      #1;
      chk("f3_os", 32'(f3_os), 32'd1);
      chk("f3_od", f3_od, 32'hBB00_0001);
    end
    @(negedge clk);
    f3_iv = 3'b111;
    #1;
    chk("f3_all_ir", 32'(f3_ir), 32'b001);
    @(posedge clk);
    #1;
    chk("f3_all_os", 32'(f3_os), 32'd0);
    chk("f3_all_od", f3_od, 32'hAA00_0000);
    @(negedge clk);
    f3_iv = 3'b000;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
